// File: rtl/flopenr_pipe.sv
// Elastic valid/ready register chain with global stall and synchronous flush.
// Optional occupancy output enabled by defining FLOPENR_PIPE_COUNT_EN.
module flopenr_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
`ifdef FLOPENR_PIPE_COUNT_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] count
`endif
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  r_q   [STAGES];
  logic [WIDTH-1:0]  r_d   [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];

  // Each stage is fed by its upstream neighbour; stage 0 by the input port.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_v[gi] = in_valid;
        assign src_r[gi] = d;
      end else begin : g_link
        assign src_v[gi] = v_q[gi-1];
        assign src_r[gi] = r_q[gi-1];
      end
    end
  endgenerate

  // A stage may advance when it is empty or its successor is advancing,
  // so bubbles are squeezed out even while the output is blocked.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = en & ~flush & (~v_q[STAGES-1] | out_ready);
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = en & ~flush & (~v_q[i] | adv[i+1]);
    end
  end

  always_comb begin
    v_d = v_q;
    r_d = r_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (adv[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) begin
          r_d[i] = src_r[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign q         = r_q[STAGES-1];

`ifdef FLOPENR_PIPE_COUNT_EN
  localparam int CW = $clog2(STAGES + 1);

  // Derived purely from the valid registers, so it tracks current occupancy.
  always_comb begin
    count = '0;
    for (int i = 0; i < STAGES; i++) begin
      count = count + CW'(v_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed self-checking bench for flopenr_pipe (WIDTH=8, STAGES=3).
// Occupancy checks are included when FLOPENR_PIPE_COUNT_EN is defined.
module tb_flopenr_pipe;

  logic       clk_in;
  logic       rst_in;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
`ifdef FLOPENR_PIPE_COUNT_EN
  logic [1:0] count;
`endif

  int checks;
  int failures;

  flopenr_pipe #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'h00)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
`ifdef FLOPENR_PIPE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_out(input string name, input logic exp_v, input logic [7:0] exp_q);
    checks++;
    if (out_valid !== exp_v || (exp_v && q !== exp_q)) begin
      failures++;
      $display("FAIL %s: out_valid=%b q=%h expected out_valid=%b q=%h", name, out_valid, q, exp_v, exp_q);
    end
  endtask

  task automatic test_reset;
    en = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 8'(8'hA1 + k);
      tick;
    end
    in_valid = 1'b0;
    chk_out("reset_preload", 1'b1, 8'hA1);
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || q !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: out_valid=%b q=%h expected out_valid=0 q=00", out_valid, q);
    end
    tick;
    rst_in = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
`ifdef FLOPENR_PIPE_COUNT_EN
    checks++;
    if (count !== 2'd0) begin
      failures++;
      $display("FAIL reset_count: count=%0d expected 0", count);
    end
`endif
    $display("test_reset done");
  endtask

  task automatic test_stream;
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    en = 1'b1; flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      d = words[k];
      tick;
    end
    in_valid = 1'b0;
    chk_out("stream_e2", 1'b1, 8'h11);
    tick;
    chk_out("stream_e3", 1'b1, 8'h22);
    tick;
    chk_out("stream_e4", 1'b1, 8'h33);
    tick;
    chk_out("stream_e5", 1'b0, 8'h00);
    $display("test_stream done");
  endtask

  task automatic test_backpressure;
    int idx;
    logic [7:0] exp_q;
    en = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      d = 8'(8'h41 + idx);
      #1;
      checks++;
      if (in_ready !== (idx < 3)) begin
        failures++;
        $display("FAIL bp_in_ready: cycle=%0d in_ready=%b expected %b", c, in_ready, (idx < 3));
      end
      if (idx < 3) idx++;
      tick;
    end
`ifdef FLOPENR_PIPE_COUNT_EN
    checks++;
    if (count !== 2'd3) begin
      failures++;
      $display("FAIL bp_count: count=%0d expected 3", count);
    end
`endif
    out_ready = 1'b1;
    exp_q = 8'h41;
    for (int c = 0; c < 5; c++) begin
      chk_out("bp_drain", 1'b1, exp_q);
      in_valid = (idx < 5);
      d = 8'(8'h41 + idx);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_flow_ready: cycle=%0d in_ready=%b expected 1", c, in_ready);
      end
      if (idx < 5) idx++;
      tick;
      exp_q = exp_q + 8'h01;
    end
    in_valid = 1'b0;
    chk_out("bp_empty", 1'b0, 8'h00);
    $display("test_backpressure done");
  endtask

  task automatic test_bubble;
    en = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; d = 8'hA1;
    tick;
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1; d = 8'hA2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bubble_ready: in_ready=%b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
`ifdef FLOPENR_PIPE_COUNT_EN
    checks++;
    if (count !== 2'd2) begin
      failures++;
      $display("FAIL bubble_count: count=%0d expected 2", count);
    end
`endif
    tick;
    chk_out("bubble_head", 1'b1, 8'hA1);
    out_ready = 1'b1;
    tick;
    chk_out("bubble_second", 1'b1, 8'hA2);
    tick;
    chk_out("bubble_empty", 1'b0, 8'h00);
    $display("test_bubble done");
  endtask

  task automatic test_stall;
    en = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; d = 8'h10;
    tick;
    d = 8'h20;
    tick;
    in_valid = 1'b0;
    tick;
    chk_out("stall_loaded", 1'b1, 8'h10);
    en = 1'b0; in_valid = 1'b1; d = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready: cycle=%0d in_ready=%b expected 0", c, in_ready);
      end
      tick;
      chk_out("stall_frozen", 1'b1, 8'h10);
`ifdef FLOPENR_PIPE_COUNT_EN
      checks++;
      if (count !== 2'd2) begin
        failures++;
        $display("FAIL stall_count: count=%0d expected 2", count);
      end
`endif
    end
    en = 1'b1; in_valid = 1'b0;
    tick;
    chk_out("stall_resume", 1'b1, 8'h20);
    tick;
    chk_out("stall_empty", 1'b0, 8'h00);
    $display("test_stall done");
  endtask

  task automatic test_flush;
    en = 1'b1; flush = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      d = 8'(8'h61 + k);
      tick;
    end
    chk_out("flush_loaded", 1'b1, 8'h61);
    flush = 1'b1; in_valid = 1'b1; d = 8'h77; en = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: in_ready=%b expected 0", in_ready);
    end
    tick;
    flush = 1'b0; in_valid = 1'b0; en = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || q !== 8'h61) begin
      failures++;
      $display("FAIL flush_clear: out_valid=%b q=%h expected out_valid=0 q=61", out_valid, q);
    end
`ifdef FLOPENR_PIPE_COUNT_EN
    checks++;
    if (count !== 2'd0) begin
      failures++;
      $display("FAIL flush_count: count=%0d expected 0", count);
    end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk_out("flush_no_leak", 1'b0, 8'h00);
    end
    $display("test_flush done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_in = 1'b0; en = 1'b0; flush = 1'b0;
    in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
    tick;
    tick;
    rst_in = 1'b1;
    tick;
    test_reset;
    test_stream;
    test_backpressure;
    test_bubble;
    test_stall;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
